// File: rtl/button_pkg.sv
// button_pkg: shared types and default timing for the button conditioner.
// Default timings assume a 65 MHz system clock.
// Optional feature macro: BUTTON_CONDITIONER_AUTO_REPEAT_EN (uses rpt_state_e).
package button_pkg;

    // System clock the default timings are derived from.
    localparam int unsigned CLK_HZ_65MHZ        = 32'd65_000_000;

    // About 15.4 ms of stability before a new level is accepted.
    localparam int unsigned DB_COUNT_65MHZ      = CLK_HZ_65MHZ / 32'd65;

    // Hold for 0.5 s before the first auto-repeat pulse.
    localparam int unsigned REPEAT_DELAY_65MHZ  = CLK_HZ_65MHZ / 32'd2;

    // Then repeat every 100 ms while the button stays held.
    localparam int unsigned REPEAT_PERIOD_65MHZ = CLK_HZ_65MHZ / 32'd10;

    // Per-channel auto-repeat state.
    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_e;

    // Larger of two timing constants; sizes the shared repeat timer.
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_conditioner_debounce_ch.sv
// debounce_ch: one button channel.
// It covers the 2-flop synchroniser, the stability counter, the clean level,
// and the registered rise/fall pulses.
// With BUTTON_CONDITIONER_AUTO_REPEAT_EN defined it also holds an auto-repeat FSM.
// Without that macro, repeat_o is tied low.
module debounce_ch
    import button_pkg::*;
#(
    parameter int unsigned DB_COUNT      = DB_COUNT_65MHZ,
    parameter int unsigned CNT_W         = $clog2(DB_COUNT + 32'd1),
    parameter int unsigned REPEAT_DELAY  = REPEAT_DELAY_65MHZ,
    parameter int unsigned REPEAT_PERIOD = REPEAT_PERIOD_65MHZ
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic noisy_i,
    output logic clean_o,
    output logic rise_o,
    output logic fall_o,
    output logic repeat_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_COUNT - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

    logic             meta_q;
    logic             sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             clean_q;
    logic             clean_d;
    logic             rise_q;
    logic             rise_d;
    logic             fall_q;
    logic             fall_d;

    // Two-stage synchroniser bringing the asynchronous pin into clk_i.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= noisy_i;
            sync_q <= meta_q;
        end
    end

    // Stability counter: the level flips only after DB_COUNT consecutive
    // differing samples; any sample matching the clean level restarts it.
    always_comb begin
        clean_d = clean_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync_q == clean_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            clean_d = sync_q;
            cnt_d   = '0;
            rise_d  = sync_q;
            fall_d  = ~sync_q;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Counter, clean level and edge pulses.
    // Pulses are registered on the same edge as the level change.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            clean_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign clean_o = clean_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
    localparam int unsigned TMR_W = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD) + 32'd1);
    localparam logic [TMR_W-1:0] DELAY_LAST  = TMR_W'(REPEAT_DELAY - 32'd1);
    localparam logic [TMR_W-1:0] PERIOD_LAST = TMR_W'(REPEAT_PERIOD - 32'd1);
    localparam logic [TMR_W-1:0] TMR_ONE     = TMR_W'(32'd1);

    rpt_state_e       state_q;
    rpt_state_e       state_d;
    logic [TMR_W-1:0] tmr_q;
    logic [TMR_W-1:0] tmr_d;
    logic             rpt_q;
    logic             rpt_d;

    // Repeat FSM next state.
    // It keys off the next clean level, so the DELAY window starts on the rise edge itself.
    // A release cancels the FSM on the very edge the level drops.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        rpt_d   = 1'b0;
        if (!clean_d) begin
            state_d = RPT_IDLE;
            tmr_d   = '0;
        end else begin
            case (state_q)
                RPT_IDLE: begin
                    tmr_d = '0;
                    if (rise_d) begin
                        state_d = RPT_DELAY;
                    end else begin
                        state_d = RPT_IDLE;
                    end
                end
                RPT_DELAY: begin
                    if (tmr_q == DELAY_LAST) begin
                        rpt_d   = 1'b1;
                        state_d = RPT_REPEAT;
                        tmr_d   = '0;
                    end else begin
                        tmr_d = tmr_q + TMR_ONE;
                    end
                end
                RPT_REPEAT: begin
                    if (tmr_q == PERIOD_LAST) begin
                        rpt_d = 1'b1;
                        tmr_d = '0;
                    end else begin
                        tmr_d = tmr_q + TMR_ONE;
                    end
                end
                default: begin
                    state_d = RPT_IDLE;
                    tmr_d   = '0;
                end
            endcase
        end
    end

    // Repeat FSM state, timer and registered repeat pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RPT_IDLE;
            tmr_q   <= '0;
            rpt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            rpt_q   <= rpt_d;
        end
    end

    assign repeat_o = rpt_q;
`else
    assign repeat_o = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: multi-channel synchroniser, debouncer and edge pulser.
// It instantiates NUM_CH independent debounce_ch channels.
// Optional feature macro: BUTTON_CONDITIONER_AUTO_REPEAT_EN.
// It enables the per-channel auto-repeat pulses on repeat_pulse_out.
module button_conditioner
    import button_pkg::*;
#(
    parameter int unsigned NUM_CH        = 32'd5,
    parameter int unsigned DB_COUNT      = DB_COUNT_65MHZ,
    parameter int unsigned CNT_W         = $clog2(DB_COUNT + 32'd1),
    parameter int unsigned REPEAT_DELAY  = REPEAT_DELAY_65MHZ,
    parameter int unsigned REPEAT_PERIOD = REPEAT_PERIOD_65MHZ
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [NUM_CH-1:0] noisy_in,
    output logic [NUM_CH-1:0] clean_out,
    output logic [NUM_CH-1:0] rise_pulse_out,
    output logic [NUM_CH-1:0] fall_pulse_out,
    output logic [NUM_CH-1:0] repeat_pulse_out,
    output logic              any_rise_out
);

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        debounce_ch #(
            .DB_COUNT      (DB_COUNT),
            .CNT_W         (CNT_W),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_ch (
            .clk_i    (clk_in),
            .rst_ni   (rst_in),
            .noisy_i  (noisy_in[ch]),
            .clean_o  (clean_out[ch]),
            .rise_o   (rise_pulse_out[ch]),
            .fall_o   (fall_pulse_out[ch]),
            .repeat_o (repeat_pulse_out[ch])
        );
    end

    // The inputs to this OR are registered pulses, so it needs no extra flop stage.
    assign any_rise_out = |rise_pulse_out;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner.
// Configuration: NUM_CH=3, DB_COUNT=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
// Expected output snapshots are queued per cycle as stimulus is applied.
// They are popped and compared at the falling edge.
module tb_button_conditioner;

    localparam int NCH = 3;
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
    localparam bit RPT_ON = 1'b1;
`else
    localparam bit RPT_ON = 1'b0;
`endif

    logic           clk_in = 1'b0;
    logic           rst_in;
    logic [NCH-1:0] noisy_in;
    logic [NCH-1:0] clean_out;
    logic [NCH-1:0] rise_pulse_out;
    logic [NCH-1:0] fall_pulse_out;
    logic [NCH-1:0] repeat_pulse_out;
    logic           any_rise_out;

    button_conditioner #(
        .NUM_CH        (NCH),
        .DB_COUNT      (4),
        .REPEAT_DELAY  (10),
        .REPEAT_PERIOD (3)
    ) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .noisy_in         (noisy_in),
        .clean_out        (clean_out),
        .rise_pulse_out   (rise_pulse_out),
        .fall_pulse_out   (fall_pulse_out),
        .repeat_pulse_out (repeat_pulse_out),
        .any_rise_out     (any_rise_out)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int         cyc;
        logic [9:0] val;
        logic [2:0] rep;
        bit         chk_rep;
    } exp_t;
    exp_t sb[$];

    function automatic logic [9:0] obs();
        return {clean_out, rise_pulse_out, fall_pulse_out, any_rise_out};
    endfunction

    task automatic push(input int c, input logic [2:0] cl, input logic [2:0] ri,
                        input logic [2:0] fa, input logic an, input logic [2:0] rp,
                        input bit cr);
        exp_t e;
        e.cyc = c; e.val = {cl, ri, fa, an}; e.rep = rp; e.chk_rep = cr;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        int   c0;
        rst_in = 1'b1; noisy_in = '0;
        #1 rst_in = 1'b0; noisy_in = 3'b111;
        c0 = cyc;
        for (int k = 1; k <= 5; k++) push(c0 + k, 3'b0, 3'b0, 3'b0, 1'b0, 3'b0, 1'b1);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk_in);
            while (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front(); n_vec++;
                if (obs() !== e.val || repeat_pulse_out !== e.rep) begin
                    n_err++;
                    $display("FAIL reset_hold cyc=%0d outs got=%b exp=%b rep got=%b exp=%b",
                             cyc, obs(), e.val, repeat_pulse_out, e.rep);
                end
            end
        end
        noisy_in = '0; rst_in = 1'b1; c0 = cyc;
        for (int k = 1; k <= 8; k++) push(c0 + k, 3'b0, 3'b0, 3'b0, 1'b0, 3'b0, 1'b1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_in);
            while (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front(); n_vec++;
                if (obs() !== e.val || repeat_pulse_out !== e.rep) begin
                    n_err++;
                    $display("FAIL reset_idle cyc=%0d outs got=%b exp=%b rep got=%b exp=%b",
                             cyc, obs(), e.val, repeat_pulse_out, e.rep);
                end
            end
        end
        if (sb.size() != 0) begin
            n_err++; $display("FAIL reset %0d expected vectors never reached", sb.size()); sb.delete();
        end
    endtask

    task automatic test_press();
        exp_t e;
        int   c0;
        noisy_in[0] = 1'b1; c0 = cyc;
        for (int k = 1; k <= 9; k++)
            push(c0 + k, {2'b0, k >= 6}, {2'b0, k == 6}, 3'b0, k == 6, 3'b0, 1'b0);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk_in);
            while (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front(); n_vec++;
                if (obs() !== e.val) begin
                    n_err++;
                    $display("FAIL press cyc=%0d clean/rise/fall/any got=%b exp=%b", cyc, obs(), e.val);
                end
            end
        end
        if (sb.size() != 0) begin
            n_err++; $display("FAIL press %0d expected vectors never reached", sb.size()); sb.delete();
        end
    endtask

    task automatic test_release();
        exp_t e;
        int   c0;
        @(negedge clk_in);
        noisy_in[0] = 1'b0; c0 = cyc;
        for (int k = 1; k <= 9; k++)
            push(c0 + k, {2'b0, k < 6}, 3'b0, {2'b0, k == 6}, 1'b0, 3'b0, 1'b0);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk_in);
            while (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front(); n_vec++;
                if (obs() !== e.val) begin
                    n_err++;
                    $display("FAIL release cyc=%0d clean/rise/fall/any got=%b exp=%b", cyc, obs(), e.val);
                end
            end
        end
        if (sb.size() != 0) begin
            n_err++; $display("FAIL release %0d expected vectors never reached", sb.size()); sb.delete();
        end
    endtask

    task automatic test_bounce();
        exp_t e;
        int   c0;
        @(negedge clk_in);
        noisy_in[1] = 1'b1; c0 = cyc;
        for (int k = 1; k <= 24; k++)
            push(c0 + k, {1'b0, k >= 18, 1'b0}, {1'b0, k == 18, 1'b0}, 3'b0, k == 18, 3'b0, 1'b0);
        for (int k = 1; k <= 26; k++) begin
            @(negedge clk_in);
            while (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front(); n_vec++;
                if (obs() !== e.val) begin
                    n_err++;
                    $display("FAIL bounce cyc=%0d clean/rise/fall/any got=%b exp=%b", cyc, obs(), e.val);
                end
            end
            if (k == 3 || k == 9) noisy_in[1] = 1'b0;
            if (k == 6 || k == 12) noisy_in[1] = 1'b1;
        end
        if (sb.size() != 0) begin
            n_err++; $display("FAIL bounce %0d expected vectors never reached", sb.size()); sb.delete();
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        int   c1;
        @(negedge clk_in);
        noisy_in[0] = 1'b1;
        @(negedge clk_in);
        @(negedge clk_in);
        #2 rst_in = 1'b0;
        #1;
        n_vec++;
        if ({obs(), repeat_pulse_out} !== 13'b0) begin
            n_err++; $display("FAIL async_reset_immediate outs got=%b exp=0", {obs(), repeat_pulse_out});
        end
        @(posedge clk_in);
        @(negedge clk_in);
        n_vec++;
        if ({obs(), repeat_pulse_out} !== 13'b0) begin
            n_err++; $display("FAIL async_reset_held outs got=%b exp=0", {obs(), repeat_pulse_out});
        end
        @(negedge clk_in);
        rst_in = 1'b1; c1 = cyc;
        for (int k = 1; k <= 9; k++)
            push(c1 + k, {1'b0, k >= 6, k >= 6}, {1'b0, k == 6, k == 6}, 3'b0, k == 6, 3'b0, 1'b0);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk_in);
            while (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front(); n_vec++;
                if (obs() !== e.val) begin
                    n_err++;
                    $display("FAIL async_reset_release cyc=%0d clean/rise/fall/any got=%b exp=%b",
                             cyc, obs(), e.val);
                end
            end
        end
        if (sb.size() != 0) begin
            n_err++; $display("FAIL async_reset %0d expected vectors never reached", sb.size()); sb.delete();
        end
    endtask

    task automatic test_simultaneous();
        exp_t e;
        int   c0;
        noisy_in = '0;
        repeat (12) @(negedge clk_in);
        noisy_in = 3'b111; c0 = cyc;
        for (int k = 1; k <= 9; k++)
            push(c0 + k, {3{k >= 6}}, {3{k == 6}}, 3'b0, k == 6, 3'b0, 1'b0);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk_in);
            while (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front(); n_vec++;
                if (obs() !== e.val) begin
                    n_err++;
                    $display("FAIL simultaneous cyc=%0d clean/rise/fall/any got=%b exp=%b", cyc, obs(), e.val);
                end
            end
        end
        if (sb.size() != 0) begin
            n_err++; $display("FAIL simultaneous %0d expected vectors never reached", sb.size()); sb.delete();
        end
    endtask

    task automatic test_repeat();
        exp_t e;
        int   c0;
        logic r;
        noisy_in = '0;
        repeat (12) @(negedge clk_in);
        noisy_in[2] = 1'b1; c0 = cyc;
        for (int k = 1; k <= 45; k++) begin
            r = RPT_ON && (k >= 16) && (k < 36) && ((k - 16) % 3 == 0);
            push(c0 + k, {k >= 6 && k < 36, 2'b0}, {k == 6, 2'b0}, {k == 36, 2'b0},
                 k == 6, {r, 2'b0}, 1'b1);
        end
        for (int k = 1; k <= 48; k++) begin
            @(negedge clk_in);
            while (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front(); n_vec++;
                if (obs() !== e.val || repeat_pulse_out !== e.rep) begin
                    n_err++;
                    $display("FAIL repeat cyc=%0d outs got=%b exp=%b rep got=%b exp=%b",
                             cyc, obs(), e.val, repeat_pulse_out, e.rep);
                end
            end
            if (k == 30) noisy_in[2] = 1'b0;
        end
        if (sb.size() != 0) begin
            n_err++; $display("FAIL repeat %0d expected vectors never reached", sb.size()); sb.delete();
        end
    endtask

    initial begin
        test_reset();
        test_press();
        test_release();
        test_bounce();
        test_async_reset();
        test_simultaneous();
        test_repeat();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Parametrised multi-channel successor to the single-channel debounce + pulser pair.
- Synchronises, debounces and edge-detects NUM_CH raw pushbutton/switch inputs in one block.
- Emits clean levels plus one-cycle press and release pulses per channel.
- Sits between board pins and user_io/game logic, replacing per-button debounce/pulser instances.

Parameters:
- NUM_CH, 5, number of independent input channels.
- DB_COUNT, 1_000_000, consecutive stable cycles required to accept a new level (>=2).
- CNT_W, $clog2(DB_COUNT+1), stability counter width (derived; do not override).
- REPEAT_DELAY, 32_500_000, hold cycles before the first auto-repeat pulse (used only with AUTO_REPEAT_EN).
- REPEAT_PERIOD, 6_500_000, cycles between subsequent auto-repeat pulses (used only with AUTO_REPEAT_EN).

Ports:
- clk_in  input  1  system clock (65 MHz domain).
- rst_in  input  1  reset; asynchronous, active-low.
- noisy_in  input  NUM_CH  raw asynchronous button/switch levels.
- clean_out  output  NUM_CH  debounced levels.
- rise_pulse_out  output  NUM_CH  one-cycle pulse on accepted 0->1 transition.
- fall_pulse_out  output  NUM_CH  one-cycle pulse on accepted 1->0 transition.
- repeat_pulse_out  output  NUM_CH  auto-repeat pulses while held (0 without AUTO_REPEAT_EN).
- any_rise_out  output  1  OR of rise_pulse_out.

Behaviour:
- Reset (rst_in=0, async): sync flops, counters, clean_out, all pulse outputs and repeat timers = 0.
- Per channel: 2-flop synchroniser on noisy_in; its output is sync_q. Channels are fully independent.
- Stability counter:
  - sync_q == clean_out: counter <= 0.
  - sync_q != clean_out and counter == DB_COUNT-1: clean_out <= sync_q, counter <= 0.
  - Otherwise: counter increments.
- clean_out therefore flips after exactly DB_COUNT consecutive differing cycles of sync_q.
- Latency from a noisy_in change to clean_out change = 2 + DB_COUNT clock edges.
- Any glitch back to the current clean level restarts the count from 0. A bounce shorter than DB_COUNT never reaches the outputs.
- Pulse outputs are registered:
  - rise_pulse_out is high for exactly one cycle, on the same edge clean_out goes 1.
  - fall_pulse_out is likewise high for one cycle, on the same edge clean_out goes 0.
  - rise and fall are never both high on one channel.
  - any_rise_out is combinational OR of the registered rise_pulse_out.
- A steady-high input at reset release yields clean_out=1 plus one rise pulse after 2+DB_COUNT cycles. This is intended.
- Reset asserted mid-count: the count is abandoned and all outputs drop to 0 immediately. A fall pulse is never generated by reset.
- Counter never exceeds DB_COUNT-1; no wrap.

Optional Feature:
- Macro: BUTTON_CONDITIONER_AUTO_REPEAT_EN.
- Defined, per-channel repeat FSM with states IDLE, DELAY, REPEAT:
  - IDLE -> DELAY on rise_pulse_out, timer cleared.
  - DELAY: after REPEAT_DELAY cycles with clean_out=1, pulse repeat_pulse_out for one cycle and go to REPEAT.
  - REPEAT: pulse every REPEAT_PERIOD cycles.
  - clean_out=0 in any state -> IDLE the same cycle, no pulse.
  - Timer width is $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1).
- Undefined: repeat_pulse_out tied to 0 and no repeat logic is synthesised.

Decomposition:
- Package button_pkg holds:
  - the repeat FSM state enum;
  - default timing localparams DB_COUNT_65MHZ, REPEAT_DELAY_65MHZ and REPEAT_PERIOD_65MHZ, all derived from 65 MHz.
- One sub-module, debounce_ch: a single channel covering synchroniser, counter, clean level, rise/fall pulses and the optional repeat FSM.
- The top instantiates NUM_CH copies in a generate loop and forms any_rise_out.

Test Plan:
- Bench uses NUM_CH=3, DB_COUNT=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
- Clean press: noisy_in[0] 0->1 at cycle 0, held. Required: clean_out[0]=1 and rise_pulse_out[0]=1 at cycle 6 only, any_rise_out=1 at cycle 6. Channels 1 and 2 stay 0.
- Bounce rejection: noisy_in[1] toggles 1,0,1,0 every 3 cycles, then holds 1. Required: no pulses during toggling; single rise exactly 6 cycles after the final 0->1.
- Release: after channel 0 is clean high, drop noisy_in[0]. Required: fall_pulse_out[0] for one cycle 6 cycles later, clean_out[0]=0, no rise.
- Async reset mid-count: assert rst_in=0 between clock edges 2 cycles into a press. Required: all outputs 0 before the next edge, no pulse. Release and hold input: rise 6 cycles after release.
- Simultaneous channels: all three inputs rise on the same cycle. Required: three rise pulses on the same cycle, any_rise_out high for exactly one cycle.
- AUTO_REPEAT_EN defined, channel 2 held: rise at cycle 6; repeat_pulse_out[2] at cycles 16, 19, 22... Release: no further repeats once clean_out[2]=0.
